// File: rtl/ps2_scan_fifo_if.sv
// Bus between the PS/2 scan-code front end and the CPU-side input port.
// The master side drives the pins and pop; the slave side is the front end.
interface ps2_scan_fifo_if;
  logic        ps2clk;
  logic        ps2data;
  logic        pop;
  logic [31:0] out;
  logic        irq;

  modport master (output ps2clk, output ps2data, output pop, input out, input irq);
  modport slave  (input ps2clk, input ps2data, input pop, output out, output irq);
endinterface

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver: frames 11-bit serial words, folds E0/F0 prefixes
// into flags and queues {brk,ext,code} entries for the CPU.
//
// state  | meaning
// IDLE   | waiting for a start bit of 0
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit and odd parity, then back to IDLE
module ps2_scan_fifo #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 20000
) (
  input logic            clk,
  input logic            rst,
  ps2_scan_fifo_if.slave bus
);

  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT);
  localparam logic [3:0]  CNT_FULL = 4'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [15:0]   tmo;

  logic          ext, brk, ovf, err, irq_r;
  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [3:0]    count;

  logic clk_fall, frame_end, frame_good, code_push;
  logic full, empty, pop_do, push_do, ovf_set, err_set;
  logic [9:0] head_e;

  assign clk_fall   = clk_prev & ~clk_s2;
  assign frame_end  = (state == STOP) & clk_fall;
  assign frame_good = dat_s2 & (^{shift, par});
  assign code_push  = frame_end & frame_good & (shift != 8'hE0) & (shift != 8'hF0);
  assign full       = (count == CNT_FULL);
  assign empty      = (count == 4'd0);
  assign pop_do     = bus.pop & ~empty;
  // A full FIFO still accepts the push when a pop frees the head slot this cycle.
  assign push_do    = code_push & (~full | bus.pop);
  assign ovf_set    = code_push & full & ~bus.pop;
  assign err_set    = frame_end & ~frame_good;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= bus.ps2clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= bus.ps2data;
      dat_s2   <= dat_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
      par     <= 1'b0;
      tmo     <= TMO_LOAD;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
          if (clk_fall && !dat_s2) state <= DATA;
        end
        DATA: begin
          if (clk_fall) begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
        end
        PARITY: begin
          if (clk_fall) begin
            par   <= dat_s2;
            state <= STOP;
          end
        end
        STOP: begin
          if (clk_fall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Inactivity watchdog: a stalled partial frame is dropped without flagging err.
      if (state == IDLE || clk_fall) begin
        tmo <= TMO_LOAD;
      end else if (tmo == 16'd0) begin
        state <= IDLE;
      end else begin
        tmo <= tmo - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_do) mem[tail] <= {brk, ext, shift};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 4'd0;
      ext   <= 1'b0;
      brk   <= 1'b0;
      ovf   <= 1'b0;
      err   <= 1'b0;
      irq_r <= 1'b0;
    end else begin
      irq_r <= push_do;
      if (push_do) tail <= tail + PW'(1);
      if (pop_do)  head <= head + PW'(1);
      count <= count + 4'(push_do) - 4'(pop_do);
      if (frame_end && frame_good) begin
        if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
      ovf <= ovf_set | (ovf & ~bus.pop);
      err <= err_set | (err & ~bus.pop);
    end
  end

  assign head_e  = empty ? 10'd0 : mem[head];
  assign bus.out = {12'd0, count, 3'd0, err, ovf, ~empty, head_e};
  assign bus.irq = irq_r;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Self-checking bench for ps2_scan_fifo: directed scenarios plus random frames
// compared against a queue-based model of the scan-code buffer.
module tb_ps2_scan_fifo;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_scan_fifo_if bus ();
  ps2_scan_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int irq_seen = 0;
  int irq_exp = 0;

  logic [9:0] q[$];
  bit m_ext, m_brk, m_ovf, m_err;

  always @(negedge clk) if (!rst && bus.irq === 1'b1) irq_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_out();
    logic [31:0] w;
    logic [9:0] h;
    h = (q.size() > 0) ? q[0] : 10'd0;
    w = 32'd0;
    w[9:0]   = h;
    w[10]    = (q.size() > 0);
    w[11]    = m_ovf;
    w[12]    = m_err;
    w[19:16] = 4'(q.size());
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic model_frame(input logic [7:0] code, input bit good, input bit popnow);
    bit was_full, ovf_new, err_new;
    was_full = (q.size() == DEPTH);
    ovf_new = 0;
    err_new = 0;
    if (popnow && q.size() > 0) void'(q.pop_front());
    if (!good) err_new = 1;
    else if (code == 8'hE0) m_ext = 1;
    else if (code == 8'hF0) m_brk = 1;
    else begin
      if (!was_full || popnow) begin
        q.push_back({m_brk, m_ext, code});
        irq_exp++;
      end else ovf_new = 1;
      m_ext = 0;
      m_brk = 0;
    end
    if (popnow) begin
      m_ovf = ovf_new;
      m_err = err_new;
    end else begin
      m_ovf = m_ovf | ovf_new;
      m_err = m_err | err_new;
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input int nbits, input int pause, input bit pop_stop);
    logic [10:0] b;
    b = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) bus.ps2data = b[i];
      repeat (3) @(negedge clk);
      bus.ps2clk = 1'b0;
      if (i == 10 && pop_stop) begin
        // pop lands in the cycle where the synchronised falling edge is seen
        @(negedge clk);
        @(negedge clk);
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      bus.ps2clk = 1'b1;
      repeat (3) @(negedge clk);
      if (i == 4 && pause > 0) repeat (pause) @(negedge clk);
    end
    @(negedge clk) bus.ps2data = 1'b1;
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] code, input bit bad_par,
                           input bit bad_stop, input int pause, input bit pop_stop);
    send_frame(code, bad_par, bad_stop, 11, pause, pop_stop);
    model_frame(code, !bad_par && !bad_stop, pop_stop);
    repeat (2) @(negedge clk);
    chk({tag, "_out"}, bus.out, exp_out());
    chk({tag, "_irq"}, irq_seen, irq_exp);
  endtask

  task automatic do_pop(input string tag);
    @(negedge clk) bus.pop = 1'b1;
    @(negedge clk) bus.pop = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    m_ovf = 0;
    m_err = 0;
    chk(tag, bus.out, exp_out());
  endtask

  initial begin
    logic [7:0] c;
    bus.ps2clk  = 1'b1;
    bus.ps2data = 1'b1;
    bus.pop     = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_out", bus.out, 32'h0);
    chk("reset_irq", {31'd0, bus.irq}, 32'h0);

    frame_chk("t1_1c", 8'h1C, 0, 0, 0, 0);
    chk("t1_word", bus.out, 32'h0001_041C);
    chk("t1_irq_once", irq_seen, 1);
    do_pop("t1_pop");
    chk("t1_empty", bus.out, 32'h0);

    frame_chk("t2_e0", 8'hE0, 0, 0, 0, 0);
    frame_chk("t2_f0", 8'hF0, 0, 0, 0, 0);
    frame_chk("t2_75", 8'h75, 0, 0, 0, 0);
    chk("t2_entry", {22'd0, bus.out[9:0]}, 32'h375);
    chk("t2_count", {28'd0, bus.out[19:16]}, 32'd1);
    do_pop("t2_pop");

    for (int i = 1; i <= 9; i++) frame_chk("t3_fill", 8'(i), 0, 0, 0, 0);
    chk("t3_full", bus.out, 32'h0008_0C01);
    for (int i = 0; i < 8; i++) do_pop("t3_drain");
    chk("t3_empty", bus.out, 32'h0);

    frame_chk("t4_badpar", 8'h1C, 1, 0, 0, 0);
    chk("t4_err", bus.out, 32'h0000_1000);
    frame_chk("t4_good", 8'h5A, 0, 0, 0, 0);
    do_pop("t4_pop");

    send_frame(8'h3C, 0, 0, 5, 0, 0);
    repeat (TIMEOUT + 100) @(negedge clk);
    frame_chk("t5_2a", 8'h2A, 0, 0, 0, 0);
    chk("t5_word", bus.out, 32'h0001_042A);
    frame_chk("t5_pause", 8'h12, 0, 0, TIMEOUT - 100, 0);
    do_pop("t5_pop1");
    do_pop("t5_pop2");

    for (int i = 0; i < 8; i++) begin
      c = 8'($urandom_range(1, 127));
      frame_chk("t6_fill", c, 0, 0, 0, 0);
    end
    frame_chk("t6_33", 8'h33, 0, 0, 0, 1);
    chk("t6_count", {28'd0, bus.out[19:16]}, 32'd8);
    chk("t6_ovf", {31'd0, bus.out[11]}, 32'd0);
    for (int i = 0; i < 7; i++) do_pop("t6_drain");
    chk("t6_tail", {22'd0, bus.out[9:0]}, 32'h033);
    do_pop("t6_last");

    send_frame(8'h55, 0, 0, 6, 0, 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_out", bus.out, 32'h0);
    frame_chk("rst_next", 8'h4B, 0, 0, 0, 0);
    chk("rst_word", bus.out, 32'h0001_044B);

    for (int n = 0; n < 30; n++) begin
      c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) c = 8'hE0;
      else if ($urandom_range(0, 7) == 0) c = 8'hF0;
      frame_chk("rnd_frame", c, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0), 0, 0);
      if ($urandom_range(0, 2) == 0) do_pop("rnd_pop");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
